// File: rtl/cache_write_combine_buffer_pkg.sv
// Shared line geometry for the write-combining buffer.
// Default word/line sizes plus helpers deriving offset and pointer field widths.
package cache_write_combine_buffer_pkg;

    localparam int WORD                  = 32;
    localparam int CACHE_LINE_SIZE       = 16;
    localparam int CACHE_LINE_BIT_LENGTH = CACHE_LINE_SIZE * 8;

    function automatic int byte_off_w(input int word_w);
        return $clog2(word_w / 8);
    endfunction

    function automatic int word_idx_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int line_off_w(input int word_w, input int words);
        return byte_off_w(word_w) + word_idx_w(words);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wcb_line_place.sv
// Places one store word into a line-wide data image and byte-strobe vector.
// Disabled bytes are zeroed so merge logic can OR the result straight in.
module wcb_line_place #(
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int IDX_W          = 2
) (
    input  logic [WORD_W/8-1:0]                w_en,
    input  logic [IDX_W-1:0]                   word_idx,
    input  logic [WORD_W-1:0]                  wdata,
    output logic [WORD_W*WORDS_PER_LINE-1:0]   line_data,
    output logic [WORDS_PER_LINE*WORD_W/8-1:0] line_strb
);

    localparam int BYTES = WORD_W / 8;

    logic [WORD_W-1:0] masked;

    always_comb begin
        masked    = '0;
        line_data = '0;
        line_strb = '0;
        for (int b = 0; b < BYTES; b++) begin
            masked[b*8 +: 8] = w_en[b] ? wdata[b*8 +: 8] : 8'h00;
        end
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
            if (word_idx == IDX_W'(w)) begin
                line_data[w*WORD_W +: WORD_W] = masked;
                line_strb[w*BYTES +: BYTES]   = w_en;
            end
        end
    end

endmodule

// File: rtl/cache_write_combine_buffer.sv
// Write-combining buffer: merges word stores into line entries held in a FIFO
// and drains closed lines through a valid/ready master port.
module cache_write_combine_buffer
    import cache_write_combine_buffer_pkg::*;
#(
    parameter int WORD_W         = WORD,
    parameter int WORDS_PER_LINE = CACHE_LINE_SIZE / (WORD / 8),
    parameter int ADDR_W         = 32,
    parameter int DEPTH          = 2,
    parameter int TIMEOUT        = 15
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                p_valid,
    output logic                                p_ready,
    input  logic [ADDR_W-1:0]                   p_addr,
    input  logic [WORD_W/8-1:0]                 p_w_en,
    input  logic [WORD_W-1:0]                   p_wdata,
    input  logic                                flush,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [ADDR_W-1:0]                   m_line_addr,
    output logic [WORD_W*WORDS_PER_LINE-1:0]    m_line_data,
    output logic [WORDS_PER_LINE*WORD_W/8-1:0]  m_line_strb,
    output logic                                empty
);

    localparam int BYTES  = WORD_W / 8;
    localparam int LINE_W = WORD_W * WORDS_PER_LINE;
    localparam int STRB_W = WORDS_PER_LINE * BYTES;
    localparam int BO_W   = byte_off_w(WORD_W);
    localparam int IDX_W  = word_idx_w(WORDS_PER_LINE);
    localparam int OFF_W  = line_off_w(WORD_W, WORDS_PER_LINE);
    localparam int PW     = ptr_w(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int TW     = $clog2(TIMEOUT + 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [DEPTH-1:0]  e_valid;
    logic [DEPTH-1:0]  e_closed;
    logic [ADDR_W-1:0] e_addr [DEPTH];
    logic [LINE_W-1:0] e_data [DEPTH];
    logic [STRB_W-1:0] e_strb [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] young;
    logic [CW-1:0] count;
    logic [TW-1:0] timer;

    logic [ADDR_W-1:0] line_addr;
    logic [IDX_W-1:0]  word_idx;
    logic [LINE_W-1:0] pl_data;
    logic [STRB_W-1:0] pl_strb;
    logic [LINE_W-1:0] pl_mask;
    logic [LINE_W-1:0] merged_data;
    logic [STRB_W-1:0] merged_strb;

    logic young_open;
    logic store;
    logic merge;
    logic alloc;
    logic pop;
    logic close_young;
    logic unused_addr;

    assign line_addr   = {p_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign word_idx    = p_addr[OFF_W-1:BO_W];
    assign unused_addr = ^p_addr[BO_W-1:0];

    wcb_line_place #(
        .WORD_W         (WORD_W),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IDX_W          (IDX_W)
    ) u_place (
        .w_en      (p_w_en),
        .word_idx  (word_idx),
        .wdata     (p_wdata),
        .line_data (pl_data),
        .line_strb (pl_strb)
    );

    always_comb begin
        pl_mask = '0;
        for (int i = 0; i < STRB_W; i++) begin
            pl_mask[i*8 +: 8] = {8{pl_strb[i]}};
        end
    end

    assign young       = (tail == '0) ? PW'(DEPTH - 1) : tail - PW'(1);
    assign young_open  = (count != '0) && !e_closed[young];
    assign merged_data = (e_data[young] & ~pl_mask) | pl_data;
    assign merged_strb = e_strb[young] | pl_strb;

    assign p_ready = (count < CW'(DEPTH));
    assign empty   = (count == '0);
    assign store   = p_valid && p_ready && (p_w_en != '0);
    assign merge   = store && young_open && !flush
                   && (e_addr[young] == line_addr);
    assign alloc   = store && !merge;
    assign m_valid = e_valid[head] && e_closed[head];
    assign pop     = m_valid && m_ready;

    // Allocation always seals the previous youngest; idle close needs no store.
    assign close_young = young_open
        && (alloc
            || (merge && (&merged_strb))
            || (!store && (flush || timer == TW'(TIMEOUT))));

    assign m_line_addr = m_valid ? e_addr[head] : '0;
    assign m_line_data = m_valid ? e_data[head] : '0;
    assign m_line_strb = m_valid ? e_strb[head] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_valid  <= '0;
            e_closed <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            timer    <= '0;
        end else begin
            if (pop) begin
                e_valid[head] <= 1'b0;
                head          <= ptr_inc(head);
            end
            if (close_young) begin
                e_closed[young] <= 1'b1;
            end
            if (merge) begin
                e_data[young] <= merged_data;
                e_strb[young] <= merged_strb;
            end
            if (alloc) begin
                e_valid[tail]  <= 1'b1;
                e_closed[tail] <= 1'b0;
                e_addr[tail]   <= line_addr;
                e_data[tail]   <= pl_data;
                e_strb[tail]   <= pl_strb;
                tail           <= ptr_inc(tail);
            end
            count <= count + CW'(alloc) - CW'(pop);
            if (store) begin
                timer <= '0;
            end else if (young_open && timer != TW'(TIMEOUT)) begin
                timer <= timer + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_write_combine_buffer.sv
// Randomised scoreboard bench for the write-combining buffer.
// A line-level model predicts closed lines; a monitor checks each drained line in order.
module tb_cache_write_combine_buffer;
    import cache_write_combine_buffer_pkg::*;

    localparam int TO    = 15;
    localparam int DEPTH = 2;
    localparam int LW    = CACHE_LINE_BIT_LENGTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p_valid = 1'b0;
    logic          p_ready;
    logic [31:0]   p_addr = '0;
    logic [3:0]    p_w_en = '0;
    logic [31:0]   p_wdata = '0;
    logic          flush = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [31:0]   m_line_addr;
    logic [LW-1:0] m_line_data;
    logic [15:0]   m_line_strb;
    logic          empty;

    cache_write_combine_buffer #(
        .WORD_W(32), .WORDS_PER_LINE(4), .ADDR_W(32),
        .DEPTH(DEPTH), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .p_valid(p_valid), .p_ready(p_ready), .p_addr(p_addr),
        .p_w_en(p_w_en), .p_wdata(p_wdata), .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_line_addr(m_line_addr), .m_line_data(m_line_data),
        .m_line_strb(m_line_strb), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   addr;
        logic [LW-1:0] data;
        logic [15:0]   strb;
    } line_t;

    line_t       exp_q[$];
    line_t       open_l;
    bit          open_v;
    int          idle_cnt;
    int          checks;
    int          failures;
    int          pops;
    line_t       last;
    logic [31:0] popped[$];
    line_t       mon_e;
    bit          mr;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Line-level reference: one open line plus a list of sealed lines.
    task automatic model_edge(input bit st, input logic [31:0] a,
                              input logic [3:0] we, input logic [31:0] d,
                              input bit fl);
        logic [31:0] la;
        int wi;
        la = a & 32'hFFFF_FFF0;
        wi = int'(a[3:2]);
        if (st) begin
            if (!(open_v && open_l.addr == la && !fl)) begin
                if (open_v) exp_q.push_back(open_l);
                open_l.addr = la;
                open_l.data = '0;
                open_l.strb = '0;
                open_v = 1'b1;
            end
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    open_l.data[(wi*4+b)*8 +: 8] = d[b*8 +: 8];
                    open_l.strb[wi*4+b] = 1'b1;
                end
            end
            idle_cnt = 0;
            if (open_l.strb == 16'hFFFF) begin
                exp_q.push_back(open_l);
                open_v = 1'b0;
            end
        end else if (open_v) begin
            if (fl || idle_cnt == TO) begin
                exp_q.push_back(open_l);
                open_v = 1'b0;
            end else begin
                idle_cnt++;
            end
        end
    endtask

    task automatic step(input bit v, input logic [31:0] a,
                        input logic [3:0] we, input logic [31:0] d,
                        input bit fl, output bit acc);
        p_valid = v;
        p_addr  = a;
        p_w_en  = we;
        p_wdata = d;
        flush   = fl;
        m_ready = mr;
        #3;
        check("p_ready", p_ready, (exp_q.size() + int'(open_v)) < DEPTH);
        check("empty", empty, exp_q.size() == 0 && !open_v);
        acc = v && p_ready;
        @(posedge clk);
        #1;
        model_edge(acc && (we != 4'h0), a, we, d, fl);
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] we,
                         input logic [31:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 64) begin
            step(1'b1, a, we, d, 1'b0, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL store_timeout addr=%h actual=stalled required=accepted", a);
        end
    endtask

    task automatic idle(input int n, input bit fl);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, fl, acc);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        p_valid = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        open_v   = 1'b0;
        idle_cnt = 0;
        check("rst_p_ready", p_ready, 1'b1);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_m_addr", m_line_addr, '0);
        check("rst_m_data", m_line_data, '0);
        check("rst_m_strb", m_line_strb, '0);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_valid", m_valid, exp_q.size() != 0);
            if (m_valid && m_ready) begin
                pops++;
                popped.push_back(m_line_addr);
                last.addr = m_line_addr;
                last.data = m_line_data;
                last.strb = m_line_strb;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop actual=%h required=none", m_line_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("line_addr", m_line_addr, mon_e.addr);
                    check("line_strb", m_line_strb, mon_e.strb);
                    check("line_data", m_line_data, mon_e.data);
                end
            end
        end
    end

    task automatic clear_last();
        last.addr = '0;
        last.data = '0;
        last.strb = '0;
        popped.delete();
    endtask

    initial begin
        bit          acc;
        int          p0;
        int          pv;
        logic [31:0] a;
        logic [3:0]  we;
        int          r;
        checks = 0;
        failures = 0;
        pops = 0;
        mr = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // single partial word closes on timeout
        clear_last();
        store(32'h1000, 4'hF, 32'hA0A1A2A3);
        idle(17, 1'b0);
        check("t1_addr", last.addr, 32'h1000);
        check("t1_strb", last.strb, 16'h000F);
        check("t1_word0", last.data[31:0], 32'hA0A1A2A3);

        // four stores complete one line
        clear_last();
        p0 = pops;
        for (int i = 0; i < 4; i++)
            store(32'h2000 + 32'(i * 4), 4'hF, 32'h1111_1111 * 32'(i + 1));
        idle(3, 1'b0);
        check("t2_pops", pops - p0, 1);
        check("t2_strb", last.strb, 16'hFFFF);

        // byte merge inside one word, closed by flush
        clear_last();
        store(32'h3004, 4'h3, 32'h11112222);
        store(32'h3004, 4'hC, 32'h33334444);
        idle(1, 1'b1);
        idle(3, 1'b0);
        check("t3_addr", last.addr, 32'h3000);
        check("t3_strb", last.strb, 16'h00F0);
        check("t3_word1", last.data[63:32], 32'h33332222);

        // full buffer stalls the store; FIFO order survives
        clear_last();
        mr = 1'b0;
        store(32'h4000, 4'hF, 32'h4);
        store(32'h5000, 4'hF, 32'h5);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h6000, 4'hF, 32'h6, 1'b0, acc);
            check("t4_stall", acc, 1'b0);
        end
        mr = 1'b1;
        step(1'b1, 32'h6000, 4'hF, 32'h6, 1'b0, acc);
        mr = 1'b0;
        if (!acc) store(32'h6000, 4'hF, 32'h6);
        mr = 1'b1;
        idle(1, 1'b1);
        idle(5, 1'b0);
        check("t4_count", popped.size(), 3);
        if (popped.size() == 3) begin
            check("t4_first", popped[0], 32'h4000);
            check("t4_second", popped[1], 32'h5000);
            check("t4_third", popped[2], 32'h6000);
        end

        // zero-enable store and reset with live entries
        do_reset();
        step(1'b1, 32'h7000, 4'h0, 32'hDEAD, 1'b0, acc);
        check("t5_wen0_acc", acc, 1'b1);
        check("t5_wen0_empty", empty, 1'b1);
        mr = 1'b0;
        store(32'h7000, 4'hF, 32'h7);
        store(32'h8000, 4'hF, 32'h8);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t5_rst_empty", empty, 1'b1);
        check("t5_rst_m_valid", m_valid, 1'b0);
        do_reset();

        // randomised traffic
        pv = 80;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) pv = (c / 500 % 3 == 0) ? 80 : ((c / 500 % 3 == 1) ? 30 : 5);
            a = 32'h0000_A000 + 32'($urandom_range(0, 3) * 16)
              + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            we = (r == 0) ? 4'h0 : ((r <= 5) ? 4'hF : 4'($urandom_range(0, 15)));
            mr = ($urandom_range(0, 99) < 70);
            step($urandom_range(0, 99) < pv, a, we, $urandom,
                 $urandom_range(0, 99) < 3, acc);
        end
        mr = 1'b1;
        idle(2, 1'b1);
        idle(20, 1'b0);
        check("drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
